// File: rtl/decoder_if.sv
// Bus bundle between the instruction decoder and its neighbours: PC/fetch,
// register file, ALU, data SRAM and LCD driver.
interface decoder_if;
   logic       cmd_start;
   logic [7:0] instr_byte;
   logic [7:0] operand1;
   logic [7:0] operand2;
   logic       lcd_done;
   logic [7:0] reg_a;
   logic [7:0] reg_b;
   logic [7:0] reg_c;
   logic [7:0] reg_d;
   logic [7:0] reg_flags;
   logic [7:0] res;
   logic [7:0] sram_rd_data;

   logic       pc_hlt;
   logic       jmp_en;
   logic [8:0] jmp_addr;
   logic [1:0] instr_size;
   logic [7:0] sram_addr;
   logic       sram_rd_en;
   logic       sram_wr_en;
   logic [7:0] sram_wr_data;
   logic [7:0] lcd_data;
   logic [7:0] data_loc;
   logic       loc_req;
   logic       strt;
   logic [7:0] reg_wr_data;
   logic [1:0] reg_wr_addr;
   logic       reg_wr_en;
   logic [2:0] alu_inst;
   logic [7:0] op_1;
   logic [7:0] op_2;

   modport master (
      input  cmd_start, instr_byte, operand1, operand2, lcd_done,
             reg_a, reg_b, reg_c, reg_d, reg_flags, res, sram_rd_data,
      output pc_hlt, jmp_en, jmp_addr, instr_size, sram_addr, sram_rd_en,
             sram_wr_en, sram_wr_data, lcd_data, data_loc, loc_req, strt,
             reg_wr_data, reg_wr_addr, reg_wr_en, alu_inst, op_1, op_2
   );

   modport slave (
      output cmd_start, instr_byte, operand1, operand2, lcd_done,
             reg_a, reg_b, reg_c, reg_d, reg_flags, res, sram_rd_data,
      input  pc_hlt, jmp_en, jmp_addr, instr_size, sram_addr, sram_rd_en,
             sram_wr_en, sram_wr_data, lcd_data, data_loc, loc_req, strt,
             reg_wr_data, reg_wr_addr, reg_wr_en, alu_inst, op_1, op_2
   );
endinterface

// File: rtl/decoder.sv
// Instruction decode/execute controller of the 8-bit CPU: samples one
// instruction per cmd_start and drives register, SRAM, ALU, jump and LCD control.
module decoder (
   input  logic      clk,
   input  logic      sys_rst,
   decoder_if.master bus
);

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, ALUWB, LCDW, DONE} state_t;

   state_t     state_q;
   logic [7:0] instr_q;
   logic       pc_hlt_q;
   logic       jmp_en_q;
   logic [8:0] jmp_addr_q;
   logic [1:0] instr_size_q;
   logic [7:0] sram_addr_q;
   logic       sram_rd_en_q;
   logic       sram_wr_en_q;
   logic [7:0] sram_wr_data_q;
   logic [7:0] lcd_data_q;
   logic [7:0] data_loc_q;
   logic       loc_req_q;
   logic       strt_q;
   logic [7:0] reg_wr_data_q;
   logic [1:0] reg_wr_addr_q;
   logic       reg_wr_en_q;
   logic [2:0] alu_inst_q;
   logic [7:0] op_1_q;
   logic [7:0] op_2_q;

   logic [7:0] rd_val;
   logic [7:0] rs_val;
   logic       unused_bits;

   function automatic logic [7:0] reg_sel(input logic [1:0] idx,
                                          input logic [7:0] a, b, c, d);
      case (idx)
         2'd0:    reg_sel = a;
         2'd1:    reg_sel = b;
         2'd2:    reg_sel = c;
         default: reg_sel = d;
      endcase
   endfunction

   function automatic logic [1:0] size_of(input logic [7:0] ins);
      if (ins[7]) size_of = 2'd1;
      else begin
         case (ins[6:4])
            3'd1, 3'd2, 3'd3, 3'd5: size_of = 2'd2;
            3'd4:                   size_of = 2'd3;
            default:                size_of = 2'd1;
         endcase
      end
   endfunction

   // Jump condition: 0 always, 1 Z, 2 C, 3 N.
   function automatic logic cond_true(input logic [1:0] cond, input logic [2:0] flags);
      case (cond)
         2'd0:    cond_true = 1'b1;
         2'd1:    cond_true = flags[0];
         2'd2:    cond_true = flags[1];
         default: cond_true = flags[2];
      endcase
   endfunction

   always_comb begin
      rd_val = reg_sel(bus.instr_byte[3:2], bus.reg_a, bus.reg_b, bus.reg_c, bus.reg_d);
      rs_val = reg_sel(bus.instr_byte[1:0], bus.reg_a, bus.reg_b, bus.reg_c, bus.reg_d);
   end

   assign unused_bits = ^{bus.operand2[7:1], bus.reg_flags[7:3]};

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q        <= IDLE;
         instr_q        <= '0;
         pc_hlt_q       <= 1'b0;
         jmp_en_q       <= 1'b0;
         jmp_addr_q     <= '0;
         instr_size_q   <= '0;
         sram_addr_q    <= '0;
         sram_rd_en_q   <= 1'b0;
         sram_wr_en_q   <= 1'b0;
         sram_wr_data_q <= '0;
         lcd_data_q     <= '0;
         data_loc_q     <= '0;
         loc_req_q      <= 1'b0;
         strt_q         <= 1'b0;
         reg_wr_data_q  <= '0;
         reg_wr_addr_q  <= '0;
         reg_wr_en_q    <= 1'b0;
         alu_inst_q     <= '0;
         op_1_q         <= '0;
         op_2_q         <= '0;
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         jmp_en_q     <= 1'b0;
         sram_rd_en_q <= 1'b0;
         sram_wr_en_q <= 1'b0;
         strt_q       <= 1'b0;
         loc_req_q    <= 1'b0;
         reg_wr_en_q  <= 1'b0;

         case (state_q)
            IDLE:  if (bus.cmd_start && !pc_hlt_q) state_q <= FETCH;
            FETCH: state_q <= EXEC;
            EXEC: begin
               instr_q      <= bus.instr_byte;
               instr_size_q <= size_of(bus.instr_byte);
               state_q      <= DONE;
               if (bus.instr_byte[7]) begin
                  op_1_q     <= rd_val;
                  op_2_q     <= rs_val;
                  alu_inst_q <= bus.instr_byte[6:4];
                  state_q    <= ALUWB;
               end else begin
                  case (bus.instr_byte[6:4])
                     3'd0: begin
                        reg_wr_addr_q <= bus.instr_byte[3:2];
                        reg_wr_data_q <= rs_val;
                        reg_wr_en_q   <= 1'b1;
                     end
                     3'd1: begin
                        reg_wr_addr_q <= bus.instr_byte[3:2];
                        reg_wr_data_q <= bus.operand1;
                        reg_wr_en_q   <= 1'b1;
                     end
                     3'd2: begin
                        sram_addr_q   <= bus.operand1;
                        sram_rd_en_q  <= 1'b1;
                        reg_wr_addr_q <= bus.instr_byte[3:2];
                        state_q       <= MEM;
                     end
                     3'd3: begin
                        sram_addr_q    <= bus.operand1;
                        sram_wr_data_q <= rd_val;
                        sram_wr_en_q   <= 1'b1;
                     end
                     3'd4: begin
                        jmp_addr_q <= {bus.operand2[0], bus.operand1};
                        jmp_en_q   <= cond_true(bus.instr_byte[1:0], bus.reg_flags[2:0]);
                     end
                     3'd5: begin
                        lcd_data_q <= rd_val;
                        data_loc_q <= bus.operand1;
                        strt_q     <= 1'b1;
                        loc_req_q  <= bus.instr_byte[0];
                        state_q    <= LCDW;
                     end
                     3'd7: if (bus.instr_byte[3:0] == 4'hF) pc_hlt_q <= 1'b1;
                     default: ;
                  endcase
               end
            end
            MEM: begin
               reg_wr_data_q <= bus.sram_rd_data;
               reg_wr_en_q   <= 1'b1;
               state_q       <= DONE;
            end
            ALUWB: begin
               reg_wr_addr_q <= instr_q[3:2];
               reg_wr_data_q <= bus.res;
               reg_wr_en_q   <= 1'b1;
               state_q       <= DONE;
            end
            LCDW: if (bus.lcd_done) state_q <= DONE;
            // Wait for cmd_start to drop so a held request runs only once.
            DONE: if (!bus.cmd_start) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.pc_hlt       = pc_hlt_q;
   assign bus.jmp_en       = jmp_en_q;
   assign bus.jmp_addr     = jmp_addr_q;
   assign bus.instr_size   = instr_size_q;
   assign bus.sram_addr    = sram_addr_q;
   assign bus.sram_rd_en   = sram_rd_en_q;
   assign bus.sram_wr_en   = sram_wr_en_q;
   assign bus.sram_wr_data = sram_wr_data_q;
   assign bus.lcd_data     = lcd_data_q;
   assign bus.data_loc     = data_loc_q;
   assign bus.loc_req      = loc_req_q;
   assign bus.strt         = strt_q;
   assign bus.reg_wr_data  = reg_wr_data_q;
   assign bus.reg_wr_addr  = reg_wr_addr_q;
   assign bus.reg_wr_en    = reg_wr_en_q;
   assign bus.alu_inst     = alu_inst_q;
   assign bus.op_1         = op_1_q;
   assign bus.op_2         = op_2_q;

endmodule

// File: tb/tb_decoder.sv
// Directed-vector bench for the instruction decoder.
module tb_decoder;

   logic clk;
   logic sys_rst;
   decoder_if bus ();

   decoder dut (.clk(clk), .sys_rst(sys_rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;

   int         rw_cnt, rw_cyc, rd_cnt, rd_cyc, wr_cnt, jmp_cnt, strt_cnt, loc_cnt;
   logic [1:0] rw_addr;
   logic [7:0] rw_data, rd_addr, wr_addr, wr_data, lcd_d, lcd_loc;
   logic [8:0] jmp_a;

   task automatic clear_obs();
      rw_cnt = 0; rw_cyc = -1; rd_cnt = 0; rd_cyc = -1; wr_cnt = 0;
      jmp_cnt = 0; strt_cnt = 0; loc_cnt = 0;
      rw_addr = 'x; rw_data = 'x; rd_addr = 'x; wr_addr = 'x; wr_data = 'x;
      lcd_d = 'x; lcd_loc = 'x; jmp_a = 'x;
   endtask

   task automatic observe(input int c);
      if (bus.reg_wr_en)  begin rw_cnt++; rw_cyc = c; rw_addr = bus.reg_wr_addr; rw_data = bus.reg_wr_data; end
      if (bus.sram_rd_en) begin rd_cnt++; rd_cyc = c; rd_addr = bus.sram_addr; end
      if (bus.sram_wr_en) begin wr_cnt++; wr_addr = bus.sram_addr; wr_data = bus.sram_wr_data; end
      if (bus.jmp_en)     begin jmp_cnt++; jmp_a = bus.jmp_addr; end
      if (bus.strt)       begin strt_cnt++; lcd_d = bus.lcd_data; lcd_loc = bus.data_loc; end
      if (bus.loc_req)    loc_cnt++;
   endtask

   // Raise cmd_start for `hold` cycles; operands optionally arrive one cycle late.
   task automatic run_instr(input logic [7:0] ins, input logic [7:0] o1, input logic [7:0] o2,
                            input int hold, input bit late, input int lcd_at, input int ncyc);
      clear_obs();
      @(posedge clk); #1;
      bus.cmd_start = 1'b1;
      if (!late) begin bus.instr_byte = ins; bus.operand1 = o1; bus.operand2 = o2; end
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         if (c == 0 && late) begin bus.instr_byte = ins; bus.operand1 = o1; bus.operand2 = o2; end
         if (c + 1 >= hold) bus.cmd_start = 1'b0;
         bus.lcd_done = (c == lcd_at);
         @(negedge clk);
         observe(c);
      end
      bus.lcd_done = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.pc_hlt, bus.jmp_en, bus.jmp_addr, bus.instr_size, bus.sram_addr, bus.sram_rd_en,
           bus.sram_wr_en, bus.sram_wr_data, bus.lcd_data, bus.data_loc, bus.loc_req, bus.strt,
           bus.reg_wr_data, bus.reg_wr_addr, bus.reg_wr_en, bus.alu_inst, bus.op_1, bus.op_2} !== '0) begin
         errors++; $display("FAIL reset_outputs got nonzero outputs exp all zero");
      end
      sys_rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.reg_wr_en !== 1'b0 || bus.pc_hlt !== 1'b0) begin
         errors++; $display("FAIL reset_release got wr_en=%b hlt=%b exp 0 0", bus.reg_wr_en, bus.pc_hlt);
      end
   endtask

   task automatic test_mov_rr();
      run_instr(8'h01, 8'h00, 8'h00, 2, 1'b0, -1, 8);
      checks++;
      if (rw_cnt !== 1 || rw_addr !== 2'd0 || rw_data !== 8'h22) begin
         errors++; $display("FAIL mov_rr got cnt=%0d addr=%0d data=%h exp 1 0 22", rw_cnt, rw_addr, rw_data);
      end
      checks++;
      if (rw_cyc < 0 || rw_cyc >= 5 || bus.instr_size !== 2'd1) begin
         errors++; $display("FAIL mov_rr_latency got cyc=%0d size=%0d exp <5 1", rw_cyc, bus.instr_size);
      end
   endtask

   task automatic test_mov_imm();
      run_instr(8'h1C, 8'h42, 8'h00, 1, 1'b1, -1, 8);
      checks++;
      if (rw_cnt !== 1 || rw_addr !== 2'd3 || rw_data !== 8'h42 || bus.instr_size !== 2'd2) begin
         errors++; $display("FAIL mov_imm got cnt=%0d addr=%0d data=%h size=%0d exp 1 3 42 2",
                            rw_cnt, rw_addr, rw_data, bus.instr_size);
      end
   endtask

   task automatic test_load();
      run_instr(8'h28, 8'h51, 8'h00, 1, 1'b1, -1, 8);
      checks++;
      if (rd_cnt !== 1 || rd_addr !== 8'h51) begin
         errors++; $display("FAIL load_rd got cnt=%0d addr=%h exp 1 51", rd_cnt, rd_addr);
      end
      checks++;
      if (rw_cnt !== 1 || rw_cyc !== rd_cyc + 1 || rw_addr !== 2'd2 || rw_data !== 8'h5A) begin
         errors++; $display("FAIL load_wb got cnt=%0d cyc=%0d/%0d addr=%0d data=%h exp 1 rd+1 2 5a",
                            rw_cnt, rw_cyc, rd_cyc, rw_addr, rw_data);
      end
   endtask

   task automatic test_store();
      run_instr(8'h34, 8'h75, 8'h00, 1, 1'b0, -1, 8);
      checks++;
      if (wr_cnt !== 1 || wr_addr !== 8'h75 || wr_data !== 8'h22 || rw_cnt !== 0) begin
         errors++; $display("FAIL store got cnt=%0d addr=%h data=%h rw=%0d exp 1 75 22 0",
                            wr_cnt, wr_addr, wr_data, rw_cnt);
      end
   endtask

   task automatic test_alu();
      run_instr(8'h81, 8'h00, 8'h00, 1, 1'b0, -1, 8);
      checks++;
      if (bus.op_1 !== 8'h11 || bus.op_2 !== 8'h22 || bus.alu_inst !== 3'd0) begin
         errors++; $display("FAIL alu_ops got op1=%h op2=%h inst=%0d exp 11 22 0", bus.op_1, bus.op_2, bus.alu_inst);
      end
      checks++;
      if (rw_cnt !== 1 || rw_addr !== 2'd0 || rw_data !== 8'hAA) begin
         errors++; $display("FAIL alu_wb got cnt=%0d addr=%0d data=%h exp 1 0 aa", rw_cnt, rw_addr, rw_data);
      end
      run_instr(8'hB6, 8'h00, 8'h00, 1, 1'b0, -1, 8);
      checks++;
      if (bus.op_1 !== 8'h22 || bus.op_2 !== 8'h33 || bus.alu_inst !== 3'd3 || rw_addr !== 2'd1 || rw_cnt !== 1) begin
         errors++; $display("FAIL alu_b6 got op1=%h op2=%h inst=%0d addr=%0d cnt=%0d exp 22 33 3 1 1",
                            bus.op_1, bus.op_2, bus.alu_inst, rw_addr, rw_cnt);
      end
   endtask

   task automatic test_lcd();
      run_instr(8'h53, 8'h07, 8'h00, 1, 1'b0, 4, 10);
      checks++;
      if (strt_cnt !== 1 || loc_cnt !== 1 || lcd_d !== 8'h11 || lcd_loc !== 8'h07 || bus.instr_size !== 2'd2) begin
         errors++; $display("FAIL lcd_loc got strt=%0d loc=%0d data=%h pos=%h size=%0d exp 1 1 11 07 2",
                            strt_cnt, loc_cnt, lcd_d, lcd_loc, bus.instr_size);
      end
      run_instr(8'h58, 8'h20, 8'h00, 1, 1'b0, 3, 10);
      checks++;
      if (strt_cnt !== 1 || loc_cnt !== 0 || lcd_d !== 8'h33 || lcd_loc !== 8'h20 || rw_cnt !== 0) begin
         errors++; $display("FAIL lcd_noloc got strt=%0d loc=%0d data=%h pos=%h rw=%0d exp 1 0 33 20 0",
                            strt_cnt, loc_cnt, lcd_d, lcd_loc, rw_cnt);
      end
   endtask

   task automatic test_jmp();
      bus.reg_flags = 8'h00;
      run_instr(8'h41, 8'h10, 8'h01, 1, 1'b0, -1, 8);
      checks++;
      if (jmp_cnt !== 0 || bus.instr_size !== 2'd3) begin
         errors++; $display("FAIL jmp_not_taken got cnt=%0d size=%0d exp 0 3", jmp_cnt, bus.instr_size);
      end
      bus.reg_flags = 8'h01;
      run_instr(8'h41, 8'h10, 8'h01, 1, 1'b0, -1, 8);
      checks++;
      if (jmp_cnt !== 1 || jmp_a !== 9'h110) begin
         errors++; $display("FAIL jmp_taken got cnt=%0d addr=%h exp 1 110", jmp_cnt, jmp_a);
      end
      bus.reg_flags = 8'h04;
      run_instr(8'h43, 8'hF0, 8'h00, 1, 1'b0, -1, 8);
      checks++;
      if (jmp_cnt !== 1 || jmp_a !== 9'h0F0) begin
         errors++; $display("FAIL jmp_neg got cnt=%0d addr=%h exp 1 0f0", jmp_cnt, jmp_a);
      end
      bus.reg_flags = 8'h00;
   endtask

   task automatic test_back_to_back();
      run_instr(8'h0E, 8'h00, 8'h00, 7, 1'b0, -1, 10);
      checks++;
      if (rw_cnt !== 1 || rw_addr !== 2'd3 || rw_data !== 8'h33) begin
         errors++; $display("FAIL held_start got cnt=%0d addr=%0d data=%h exp 1 3 33", rw_cnt, rw_addr, rw_data);
      end
      run_instr(8'h65, 8'h00, 8'h00, 1, 1'b0, -1, 6);
      checks++;
      if (rw_cnt + rd_cnt + wr_cnt + jmp_cnt + strt_cnt !== 0 || bus.instr_size !== 2'd1) begin
         errors++; $display("FAIL nop got strobes=%0d size=%0d exp 0 1",
                            rw_cnt + rd_cnt + wr_cnt + jmp_cnt + strt_cnt, bus.instr_size);
      end
   endtask

   task automatic test_halt();
      run_instr(8'h7F, 8'h00, 8'h00, 1, 1'b0, -1, 6);
      checks++;
      if (bus.pc_hlt !== 1'b1) begin
         errors++; $display("FAIL halt_set got %b exp 1", bus.pc_hlt);
      end
      run_instr(8'h01, 8'h00, 8'h00, 2, 1'b0, -1, 8);
      checks++;
      if (rw_cnt !== 0 || bus.pc_hlt !== 1'b1) begin
         errors++; $display("FAIL halt_ignore got rw=%0d hlt=%b exp 0 1", rw_cnt, bus.pc_hlt);
      end
   endtask

   task automatic test_abort();
      sys_rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.pc_hlt !== 1'b0) begin
         errors++; $display("FAIL halt_clear got %b exp 0", bus.pc_hlt);
      end
      sys_rst = 1'b0;
      clear_obs();
      @(posedge clk); #1;
      bus.instr_byte = 8'h81; bus.cmd_start = 1'b1;
      @(posedge clk); #1;
      bus.cmd_start = 1'b0;
      @(posedge clk); #1;
      sys_rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         observe(c);
         if (c == 1) sys_rst = 1'b0;
      end
      checks++;
      if (rw_cnt !== 0 || bus.op_1 !== 8'h00 || bus.reg_wr_data !== 8'h00) begin
         errors++; $display("FAIL abort got rw=%0d op1=%h wdata=%h exp 0 00 00", rw_cnt, bus.op_1, bus.reg_wr_data);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      sys_rst = 1'b1;
      bus.cmd_start = 1'b0; bus.instr_byte = 8'h00; bus.operand1 = 8'h00; bus.operand2 = 8'h00;
      bus.lcd_done = 1'b0;
      bus.reg_a = 8'h11; bus.reg_b = 8'h22; bus.reg_c = 8'h33; bus.reg_d = 8'h44;
      bus.reg_flags = 8'h00; bus.res = 8'hAA; bus.sram_rd_data = 8'h5A;
      clear_obs();

      test_reset();
      test_mov_rr();
      test_mov_imm();
      test_load();
      test_store();
      test_alu();
      test_lcd();
      test_jmp();
      test_back_to_back();
      test_halt();
      test_abort();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
